// File: rtl/hub75_bcm_scan.sv
// HUB75 scan driver: streams BCM bit planes out of a synchronous frame buffer and
// generates sclk/lat/oe/row address for a 1/SCAN_ROWS-scan panel with global brightness.
module hub75_bcm_scan #(
   parameter int COLS       = 64,
   parameter int SCAN_ROWS  = 16,
   parameter int COLOR_BITS = 4,
   parameter int BASE       = 8
) (
   input  logic                                       clk,
   input  logic                                       rst_n,
   input  logic                                       enable,
   input  logic [7:0]                                 brightness,
   output logic [$clog2(SCAN_ROWS)+$clog2(COLS)-1:0]  rd_addr,
   input  logic [3*COLOR_BITS-1:0]                    rd_data_top,
   input  logic [3*COLOR_BITS-1:0]                    rd_data_bot,
   output logic                                       r0,
   output logic                                       g0,
   output logic                                       b0,
   output logic                                       r1,
   output logic                                       g1,
   output logic                                       b1,
   output logic                                       sclk,
   output logic                                       lat,
   output logic                                       oe,
   output logic [$clog2(SCAN_ROWS)-1:0]               row_addr,
   output logic                                       frame_start
);

   localparam int ROW_BITS = $clog2(SCAN_ROWS);
   localparam int COL_BITS = $clog2(COLS);
   localparam int CNT_W    = COL_BITS + 1;
   localparam int PL_W     = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
   localparam int BB_W     = 8 + $clog2(BASE + 1);
   localparam int ON_W     = BB_W + COLOR_BITS - 1;
   localparam int D_W      = $clog2((BASE << (COLOR_BITS - 1)) + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREFETCH,
      S_SHIFT,
      S_LATCH,
      S_DISPLAY
   } state_t;

   state_t                       r_state;
   logic [ROW_BITS-1:0]          r_row;
   logic [PL_W-1:0]              r_plane;
   logic [CNT_W-1:0]             r_cnt;
   logic [D_W-1:0]               r_dcnt;
   logic [BB_W-1:0]              r_bb;
   logic                         r_shift_en;
   logic                         r_sclk;
   logic                         r_lat;
   logic                         r_oe;
   logic                         r_frame_start;
   logic [ROW_BITS-1:0]          r_row_addr;
   logic [ROW_BITS+COL_BITS-1:0] r_rd_addr;

   logic [COL_BITS-1:0]          w_pix;
   logic                         w_last_pix;
   logic                         w_last_cnt;
   logic                         w_last_plane;
   logic                         w_last_row;
   logic                         w_disp_done;
   logic [D_W-1:0]               w_len;
   logic [D_W-1:0]               w_on;
   logic [D_W-1:0]               w_dnext;
   logic [ON_W-1:0]              w_on_full;
   logic [COLOR_BITS-1:0]        w_rt, w_gt, w_bt, w_rb, w_gb, w_bb;

   // r_cnt counts half-pixels: bit 0 is the sclk phase, the upper bits the pixel index
   assign w_pix        = r_cnt[CNT_W-1:1];
   assign w_last_pix   = (w_pix == COL_BITS'(COLS - 1));
   assign w_last_cnt   = (r_cnt == CNT_W'(2 * COLS - 1));
   assign w_last_plane = (r_plane == PL_W'(COLOR_BITS - 1));
   assign w_last_row   = (r_row == ROW_BITS'(SCAN_ROWS - 1));

   // brightness*BASE is captured once per frame; each plane only shifts it, so nothing
   // is truncated before the final >>8
   assign w_len       = D_W'(BASE) << r_plane;
   assign w_on_full   = ON_W'(r_bb) << r_plane;
   assign w_on        = D_W'(w_on_full >> 8);
   assign w_dnext     = r_dcnt + D_W'(1);
   assign w_disp_done = (w_dnext == w_len);

   assign w_rt = rd_data_top[2*COLOR_BITS +: COLOR_BITS];
   assign w_gt = rd_data_top[COLOR_BITS +: COLOR_BITS];
   assign w_bt = rd_data_top[0 +: COLOR_BITS];
   assign w_rb = rd_data_bot[2*COLOR_BITS +: COLOR_BITS];
   assign w_gb = rd_data_bot[COLOR_BITS +: COLOR_BITS];
   assign w_bb = rd_data_bot[0 +: COLOR_BITS];

   // Frame-buffer read data arrives exactly when it must be on the lines, so the data
   // outputs are the selected plane bit gated by a registered shift-window flag.
   assign r0 = r_shift_en & w_rt[r_plane];
   assign g0 = r_shift_en & w_gt[r_plane];
   assign b0 = r_shift_en & w_bt[r_plane];
   assign r1 = r_shift_en & w_rb[r_plane];
   assign g1 = r_shift_en & w_gb[r_plane];
   assign b1 = r_shift_en & w_bb[r_plane];

   assign sclk        = r_sclk;
   assign lat         = r_lat;
   assign oe          = r_oe;
   assign row_addr    = r_row_addr;
   assign rd_addr     = r_rd_addr;
   assign frame_start = r_frame_start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_row         <= '0;
         r_plane       <= '0;
         r_cnt         <= '0;
         r_dcnt        <= '0;
         r_bb          <= '0;
         r_shift_en    <= 1'b0;
         r_sclk        <= 1'b0;
         r_lat         <= 1'b0;
         r_oe          <= 1'b1;
         r_frame_start <= 1'b0;
         r_row_addr    <= '0;
         r_rd_addr     <= '0;
      end else begin
         r_frame_start <= 1'b0;
         r_lat         <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (enable) begin
                  r_state       <= S_PREFETCH;
                  r_row         <= '0;
                  r_plane       <= '0;
                  r_frame_start <= 1'b1;
                  r_bb          <= BB_W'(brightness) * BB_W'(BASE);
                  r_rd_addr     <= '0;
               end
            end

            S_PREFETCH: begin
               r_state    <= S_SHIFT;
               r_cnt      <= '0;
               r_shift_en <= 1'b1;
            end

            // the address runs one pixel ahead, advancing as each sclk high phase starts
            S_SHIFT: begin
               r_cnt <= r_cnt + CNT_W'(1);
               if (!r_cnt[0]) begin
                  r_sclk <= 1'b1;
                  if (!w_last_pix) begin
                     r_rd_addr <= {r_row, w_pix + COL_BITS'(1)};
                  end
               end else begin
                  r_sclk <= 1'b0;
                  if (w_last_cnt) begin
                     r_state    <= S_LATCH;
                     r_lat      <= 1'b1;
                     r_shift_en <= 1'b0;
                     r_row_addr <= r_row;
                  end
               end
            end

            S_LATCH: begin
               r_state <= S_DISPLAY;
               r_dcnt  <= '0;
               r_oe    <= (w_on == '0);
            end

            S_DISPLAY: begin
               r_dcnt <= w_dnext;
               r_oe   <= (w_dnext >= w_on);
               if (w_disp_done) begin
                  r_oe <= 1'b1;
                  if (!w_last_plane) begin
                     r_plane   <= r_plane + PL_W'(1);
                     r_state   <= S_PREFETCH;
                     r_rd_addr <= {r_row, COL_BITS'(0)};
                  end else begin
                     r_plane <= '0;
                     if (!w_last_row) begin
                        r_row     <= r_row + ROW_BITS'(1);
                        r_state   <= S_PREFETCH;
                        r_rd_addr <= {r_row + ROW_BITS'(1), COL_BITS'(0)};
                     end else if (enable) begin
                        r_row         <= '0;
                        r_state       <= S_PREFETCH;
                        r_frame_start <= 1'b1;
                        r_bb          <= BB_W'(brightness) * BB_W'(BASE);
                        r_rd_addr     <= '0;
                     end else begin
                        r_row      <= '0;
                        r_state    <= S_IDLE;
                        r_row_addr <= '0;
                        r_rd_addr  <= '0;
                     end
                  end
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hub75_bcm_scan.sv
// Scoreboard bench for hub75_bcm_scan: random frame-buffer contents and brightness,
// expected frames/pixels/planes queued from the panel timing rules, checked by a monitor.
module tb_hub75_bcm_scan;

   localparam int COLS       = 4;
   localparam int SCAN_ROWS  = 2;
   localparam int COLOR_BITS = 3;
   localparam int BASE       = 8;
   localparam int ROW_BITS   = 1;
   localparam int AW         = 3;
   localparam int DW         = 3 * COLOR_BITS;
   localparam int NPIX       = SCAN_ROWS * COLS;
   localparam int ROW_CYC    = COLOR_BITS * (2 * COLS + 2) + BASE * ((1 << COLOR_BITS) - 1);
   localparam int FRAME_CYC  = SCAN_ROWS * ROW_CYC;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                enable = 1'b0;
   logic [7:0]          brightness = 8'd0;
   logic [AW-1:0]       rd_addr;
   logic [DW-1:0]       rd_data_top = '0;
   logic [DW-1:0]       rd_data_bot = '0;
   logic                r0, g0, b0, r1, g1, b1;
   logic                sclk, lat, oe;
   logic [ROW_BITS-1:0] row_addr;
   logic                frame_start;

   int top_r[NPIX], top_g[NPIX], top_b[NPIX];
   int bot_r[NPIX], bot_g[NPIX], bot_b[NPIX];

   typedef struct {
      int row;
      int on;
      int len;
   } plane_t;

   int         q_fs[$];
   logic [5:0] q_px[$];
   plane_t     q_pl[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   hub75_bcm_scan #(
      .COLS(COLS), .SCAN_ROWS(SCAN_ROWS), .COLOR_BITS(COLOR_BITS), .BASE(BASE)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .brightness(brightness),
      .rd_addr(rd_addr), .rd_data_top(rd_data_top), .rd_data_bot(rd_data_bot),
      .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
      .sclk(sclk), .lat(lat), .oe(oe), .row_addr(row_addr), .frame_start(frame_start)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // synchronous frame buffer: data for an address appears the cycle after it is presented
   always @(posedge clk) begin
      rd_data_top <= {COLOR_BITS'(top_r[rd_addr]), COLOR_BITS'(top_g[rd_addr]),
                      COLOR_BITS'(top_b[rd_addr])};
      rd_data_bot <= {COLOR_BITS'(bot_r[rd_addr]), COLOR_BITS'(bot_g[rd_addr]),
                      COLOR_BITS'(bot_b[rd_addr])};
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   function automatic logic bit_of(input int v, input int b);
      return ((v >> b) & 1) != 0;
   endfunction

   // Reference: a frame is every row, each row every plane LSB first, each plane every
   // column in order; on-time per plane is floor(brightness * BASE * 2^b / 256).
   task automatic push_frame(input int start, input int br);
      plane_t     p;
      logic [5:0] v;
      int         a;
      q_fs.push_back(start);
      for (int r = 0; r < SCAN_ROWS; r++) begin
         for (int b = 0; b < COLOR_BITS; b++) begin
            for (int k = 0; k < COLS; k++) begin
               a = r * COLS + k;
               v = {bit_of(top_r[a], b), bit_of(top_g[a], b), bit_of(top_b[a], b),
                    bit_of(bot_r[a], b), bit_of(bot_g[a], b), bit_of(bot_b[a], b)};
               q_px.push_back(v);
            end
            p.row = r;
            p.len = BASE * (1 << b);
            p.on  = (br * p.len) / 256;
            q_pl.push_back(p);
         end
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------- monitor ----------------
   logic                m_prev_sclk = 1'b0;
   logic [5:0]          m_prev_data = '0;
   logic [ROW_BITS-1:0] m_prev_row = '0;
   logic [5:0]          m_cur;
   int                  m_sclk_cnt = 0;
   int                  m_stray = 0;
   bit                  m_win = 1'b0;
   int                  m_wi = 0;
   int                  m_wlow = 0;
   int                  m_wbad = 0;
   plane_t              m_wp;

   initial begin
      forever begin
         @(negedge clk);
         m_cur = {r0, g0, b0, r1, g1, b1};
         if (!rst_n) begin
            m_win      = 1'b0;
            m_sclk_cnt = 0;
            m_stray    = 0;
         end else begin
            if (frame_start) begin
               chk("frame_start_expected", q_fs.size() != 0, 1);
               if (q_fs.size() != 0) chk("frame_start_cycle", cyc, q_fs.pop_front());
            end
            if (sclk && !m_prev_sclk) begin
               chk("data_setup_before_sclk", m_cur, m_prev_data);
               chk("pixel_expected", q_px.size() != 0, 1);
               if (q_px.size() != 0) chk("pixel_bits", m_cur, q_px.pop_front());
               m_sclk_cnt++;
            end
            if (m_win) begin
               if (!oe) m_wlow++;
               if (oe != (m_wi >= m_wp.on)) m_wbad++;
               m_wi++;
               if (m_wi == m_wp.len) begin
                  chk("oe_on_cycles", m_wlow, m_wp.on);
                  chk("oe_shape_errors", m_wbad, 0);
                  m_win = 1'b0;
               end
            end else if (!oe) begin
               m_stray++;
            end
            if (lat) begin
               chk("lat_with_sclk0_oe1", {sclk, oe}, 2'b01);
               chk("sclk_pulses_per_plane", m_sclk_cnt, COLS);
               chk("oe_low_outside_display", m_stray, 0);
               m_sclk_cnt = 0;
               m_stray    = 0;
               chk("plane_expected", q_pl.size() != 0, 1);
               if (q_pl.size() != 0) begin
                  m_wp = q_pl.pop_front();
                  chk("latch_row_addr", row_addr, m_wp.row);
                  m_win  = 1'b1;
                  m_wi   = 0;
                  m_wlow = 0;
                  m_wbad = 0;
               end
            end
            if (row_addr !== m_prev_row) begin
               chk("row_addr_change_only_latched",
                   lat || (row_addr == '0 && !m_win && q_pl.size() == 0 && oe), 1);
            end
         end
         m_prev_sclk = sclk;
         m_prev_data = m_cur;
         m_prev_row  = row_addr;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   int br_tab[5];
   int s, start, t;

   initial begin
      for (int a = 0; a < NPIX; a++) begin
         top_r[a] = $urandom_range(0, 7);
         top_g[a] = $urandom_range(0, 7);
         top_b[a] = $urandom_range(0, 7);
         bot_r[a] = $urandom_range(0, 7);
         bot_g[a] = $urandom_range(0, 7);
         bot_b[a] = $urandom_range(0, 7);
      end
      top_r[1] = 2;
      top_g[1] = 0;
      top_b[1] = 1;
      br_tab[0] = 255;
      br_tab[1] = 0;
      br_tab[2] = 128;
      br_tab[3] = $urandom_range(1, 255);
      br_tab[4] = $urandom_range(0, 255);

      rst_n      = 1'b0;
      enable     = 1'b1;
      brightness = 8'd255;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_oe", oe, 1);
      chk("reset_sclk", sclk, 0);
      chk("reset_lat", lat, 0);
      chk("reset_row_addr", row_addr, 0);
      chk("reset_rd_addr", rd_addr, 0);
      chk("reset_frame_start", frame_start, 0);
      chk("reset_data_lines", {r0, g0, b0, r1, g1, b1}, 0);

      rst_n = 1'b1;
      s = cyc + 1;
      for (int n = 0; n < 5; n++) begin
         start = s + n * FRAME_CYC;
         if (n > 0) begin
            wait_until(start - 1);
            brightness = 8'(br_tab[n]);
         end
         push_frame(start, br_tab[n]);
         wait_until(start + 3);
         brightness = 8'($urandom);
         if (n == 2) begin
            wait_until(start + 40);
            enable = 1'b0;
            wait_until(start + 60);
            enable = 1'b1;
         end
         if (n == 4) begin
            wait_until(start + ROW_CYC + 20);
            enable = 1'b0;
         end
      end

      wait_until(start + FRAME_CYC + 30);
      chk("frame_queue_drained", q_fs.size(), 0);
      chk("pixel_queue_drained", q_px.size(), 0);
      chk("plane_queue_drained", q_pl.size(), 0);
      chk("idle_oe", oe, 1);
      chk("idle_sclk", sclk, 0);
      chk("idle_lat", lat, 0);
      chk("idle_row_addr", row_addr, 0);
      chk("idle_rd_addr", rd_addr, 0);

      brightness = 8'd255;
      enable     = 1'b1;
      t = cyc;
      push_frame(t + 1, 255);
      wait_until(t + 1 + 12);
      #2;
      chk("oe_low_before_async_reset", oe, 0);
      rst_n = 1'b0;
      #1;
      chk("async_reset_oe", oe, 1);
      chk("async_reset_lat", lat, 0);
      chk("async_reset_sclk", sclk, 0);
      chk("async_reset_data_lines", {r0, g0, b0, r1, g1, b1}, 0);
      enable = 1'b0;
      q_fs.delete();
      q_px.delete();
      q_pl.delete();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      t = cyc;
      wait_until(t + 20);
      chk("post_reset_oe", oe, 1);
      chk("post_reset_row_addr", row_addr, 0);
      chk("post_reset_no_frames", q_fs.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hub75_bcm_scan.md
# hub75_bcm_scan

Parametrised HUB75 scan driver and successor to the single-bit matrix driver. It reads pixel words from an external synchronous frame buffer instead of wide flattened map buses. It generates shift clock, latch, blanking and row address for a 1/SCAN_ROWS-scan panel, and supports multi-bit colour via binary-code modulation (BCM) plus global brightness. It sits between the game's frame-buffer writer and the panel connector.

## Interface
- COLS, 64, pixels shifted per row (power of two, ≥2)
- SCAN_ROWS, 16, multiplexed row pairs (power of two); ROW_BITS = log2(SCAN_ROWS), COL_BITS = log2(COLS)
- COLOR_BITS, 4, bits per colour channel (1..8)
- BASE, 8, display cycles of bit plane 0 (≥1); plane b lasts BASE<<b cycles
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous and active-low
- enable  in  1  run scanning; sampled only in IDLE / at frame end
- brightness  in  8  global on-time scale, sampled at frame start
- rd_addr  out  ROW_BITS+COL_BITS  frame-buffer address {row,col}, registered
- rd_data_top  in  3*COLOR_BITS  {R,G,B} for top half, valid the cycle after rd_addr changes
- rd_data_bot  in  3*COLOR_BITS  same for bottom half (row+SCAN_ROWS)
- r0,g0,b0,r1,g1,b1  out  1 each  panel data lines
- sclk  out  1  panel shift clock
- lat  out  1  latch strobe, active high
- oe  out  1  output enable, high = blanked
- row_addr  out  ROW_BITS  panel {D,C,B,A}
- frame_start  out  1  one-cycle pulse at start of each frame

## Operation
- States: IDLE → PREFETCH → SHIFT → LATCH → DISPLAY → (PREFETCH next plane/row | IDLE).
- IDLE: all outputs at reset values; if enable=1, go PREFETCH with row=0, plane=0, pulse frame_start, capture brightness.
- PREFETCH (1 cycle): rd_addr={row,0}; oe=1.
- SHIFT (2*COLS cycles): per pixel k, cycle L: sclk=0, data lines = plane bits of pixel k; cycle H: sclk=1, data unchanged. rd_addr is pipelined one pixel ahead; last address is {row,COLS-1}, with no wrap read.
- Bit extraction for plane b: r0=rd_data_top[2*COLOR_BITS+b], g0=[COLOR_BITS+b], b0=[b]; same for r1/g1/b1 from rd_data_bot.
- LATCH (1 cycle): lat=1, sclk=0, oe=1; row_addr<=row on this cycle, so the address changes only while blanked.
- DISPLAY (BASE<<b cycles): oe=0 for the first on=(brightness*(BASE<<b))>>8 cycles, then oe=1 for the remainder. on=0 keeps oe high for the whole state.
- Plane order is LSB first. After the last plane, row increments. After row SCAN_ROWS-1, row wraps to 0. At the frame end, if enable=1, go to PREFETCH of the next frame (new frame_start, new brightness); otherwise go to IDLE.
- Counters: col COL_BITS+1 bits; on counter wide enough for 8+COLOR_BITS-1+log2(BASE) bits; multiply done at frame start per plane or via shift, with no truncation before >>8.

## Timing
- Reset (async assert, sync release): sclk=0, lat=0, oe=1, r0..b1=0, row_addr=0, rd_addr=0, frame_start=0, state IDLE. Reset mid-frame aborts immediately with no partial latch.
- Per plane: 1+2*COLS+1+(BASE<<b) cycles. Per row: COLOR_BITS*(2*COLS+2)+BASE*(2^COLOR_BITS−1). Defaults: 640 cycles/row, 10240 cycles/frame.
- frame_start asserts in the cycle the FSM enters PREFETCH for row 0 plane 0. Consecutive pulses are exactly one frame period apart while enable=1.
- Data lines are stable one cycle before and during each sclk high cycle. lat never coincides with oe=0 or sclk=1.
- Deasserting enable mid-frame completes the frame. Deassert and reassert within a frame causes no gap.

## Test plan
- Reset: hold rst_n=0 with enable=1 → oe=1, sclk=lat=0, row_addr=0. Release → frame_start one cycle later.
- Small config COLS=4, SCAN_ROWS=2, COLOR_BITS=2, BASE=4, brightness=255 → planes of 14/18 cycles, frame_start every 64 cycles, oe low 3 then 7 cycles per plane.
- Pixel pattern top={R=2'b10,G=0,B=2'b01} at col 1 → plane0 shifts b0=1 at col 1, plane1 shifts r0=1 at col 1; 4 sclk rising edges per plane, lat pulse after the 4th.
- brightness=0 → oe stays 1 for the whole frame while sclk/lat still toggle. brightness=128, BASE=8, plane 2 → oe low 16 of 32 cycles.
- Drop enable mid-row 1 → frame completes through row 1 plane 1, then IDLE, with no further frame_start. Also check row_addr changes only in LATCH cycles.
- Async reset asserted during DISPLAY → oe rises and lat=0 immediately, with no clk edge needed.
